// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL word window, byte FIFO, LSB-first shifter.
// Stores to a full FIFO are dropped and latch a sticky overflow flag; tx is a registered output.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [29:0]   BASE_W    = BASE_ADDR[31:2];

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Register decode on word address; byte lanes are ignored.
  logic sel_tx, sel_st, sel_ctrl;
  assign sel_tx   = (DataAdr[31:2] == BASE_W);
  assign sel_st   = (DataAdr[31:2] == BASE_W + 30'd1);
  assign sel_ctrl = (DataAdr[31:2] == BASE_W + 30'd2);
  assign hit      = sel_tx | sel_st | sel_ctrl;

  logic unused_bits;
  assign unused_bits = ^{DataAdr[1:0], WriteData[31:8]};

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          enable_q, overflow_q;
  logic          full, empty, push, pop, wr_txdata;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q;
  logic          baud_last;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign wr_txdata = MemWrite & sel_tx;
  assign push      = wr_txdata & ~full;
  assign pop       = (state_q == S_IDLE) & enable_q & ~empty;
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      enable_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      // full is the pre-edge value, so a same-cycle pop never rescues this store
      if (wr_txdata && full) overflow_q <= 1'b1;
      else if (MemWrite && sel_st && WriteData[6]) overflow_q <= 1'b0;
      if (MemWrite && sel_ctrl) enable_q <= WriteData[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

  logic [2:0] count3;
  assign count3 = 3'(count_q);

  always_comb begin
    ReadData = '0;
    if (sel_st)
      ReadData = {25'b0, overflow_q, count3, busy_q, empty, full};
    else if (sel_ctrl)
      ReadData = {31'b0, enable_q};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a waveform-level reference model.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;
  logic        tx;
  logic        busy;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .hit       (hit),
    .tx        (tx),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: byte queue, pending line waveform (one entry per clock), enable and overflow flags.
  byte unsigned m_q[$];
  bit           m_wave[$];
  bit           m_en  = 1'b1;
  bit           m_ovf = 1'b0;

  function automatic int reg_sel(input logic [31:0] adr);
    if (adr >= BASE && adr < BASE + 32'd12) return int'((adr - BASE) >> 2);
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] adr);
    logic [31:0] r;
    logic [2:0]  cnt;
    r   = '0;
    cnt = 3'(m_q.size());
    case (reg_sel(adr))
      1: r = {25'b0, m_ovf, cnt, (m_wave.size() > 0), (m_q.size() == 0), (m_q.size() == DEPTH)};
      2: r = {31'b0, m_en};
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_step(input bit rst_n, input bit mw, input logic [31:0] adr, input logic [31:0] wd);
    bit         idle, was_full, en_pre;
    bit [7:0]   b;
    if (!rst_n) begin
      m_q.delete();
      m_wave.delete();
      m_en  = 1'b1;
      m_ovf = 1'b0;
      return;
    end
    idle     = (m_wave.size() == 0);
    was_full = (m_q.size() == DEPTH);
    en_pre   = m_en;
    if (!idle) void'(m_wave.pop_front());
    if (idle && en_pre && m_q.size() > 0) begin
      b = m_q.pop_front();
      for (int i = 0; i < CPB; i++) m_wave.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int i = 0; i < CPB; i++) m_wave.push_back(b[k]);
      for (int i = 0; i < CPB; i++) m_wave.push_back(1'b1);
    end
    if (mw) begin
      case (reg_sel(adr))
        0: if (was_full) m_ovf = 1'b1; else m_q.push_back(wd[7:0]);
        1: if (wd[6]) m_ovf = 1'b0;
        2: m_en = wd[0];
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit rst_n, input bit mw, input logic [31:0] adr, input logic [31:0] wd);
    reset     = rst_n;
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = wd;
    @(posedge clk);
    model_step(rst_n, mw, adr, wd);
    #1;
    check("tx",    {31'b0, tx},   {31'b0, (m_wave.size() > 0) ? m_wave[0] : 1'b1});
    check("busy",  {31'b0, busy}, {31'b0, (m_wave.size() > 0)});
    check("hit",   {31'b0, hit},  {31'b0, (reg_sel(adr) >= 0)});
    check("rdata", ReadData,      exp_rdata(adr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, BASE + 32'd4, 32'h0);
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] wd);
    cyc(1'b1, 1'b1, adr, wd);
  endtask

  logic [31:0] seq3 [6];

  initial begin
    seq3[0] = 32'h0D; seq3[1] = 32'h31; seq3[2] = 32'h33;
    seq3[3] = 32'h37; seq3[4] = 32'h33; seq3[5] = 32'h30;

    // reset and register defaults
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    idle(2);
    cyc(1'b1, 1'b0, BASE + 32'd8, 32'h0);
    cyc(1'b1, 1'b0, BASE, 32'h0);

    // single frame
    store(BASE, 32'h41);
    idle(50);

    // FIFO fill, overflow, overflow clear
    for (int i = 0; i < 6; i++) store(BASE, seq3[i]);
    idle(5 * 41 + 10);
    store(BASE + 32'd4, 32'h40);
    idle(2);

    // disable holds frames, enable releases them
    store(BASE + 32'd8, 32'h0);
    store(BASE, 32'hAA);
    store(BASE, 32'h55);
    idle(20);
    store(BASE + 32'd8, 32'h1);
    idle(90);

    // reset mid-frame
    store(BASE, 32'h0F);
    idle(1 + CPB + 3 * CPB + 1);
    cyc(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    idle(50);

    // out-of-window stores
    store(BASE + 32'd12, 32'h77);
    store(32'h0000_0008, 32'h78);
    cyc(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] adr, wd;
      r  = $urandom_range(0, 99);
      wd = $urandom;
      if (r < 1) begin
        cyc(1'b0, 1'($urandom_range(0, 1)), BASE, wd);
      end else if (r < 18) begin
        store(BASE + 32'($urandom_range(0, 3)), wd);
      end else if (r < 21) begin
        store(BASE + 32'd4 + 32'($urandom_range(0, 3)), wd);
      end else if (r < 24) begin
        wd[0] = ($urandom_range(0, 4) != 0);
        store(BASE + 32'd8 + 32'($urandom_range(0, 3)), wd);
      end else if (r < 27) begin
        adr = ($urandom_range(0, 1) != 0) ? (BASE + 32'($urandom_range(12, 40))) : 32'($urandom);
        store(adr, wd);
      end else begin
        adr = ($urandom_range(0, 3) != 0) ? (BASE + 32'($urandom_range(0, 15))) : 32'($urandom);
        cyc(1'b1, 1'b0, adr, wd);
      end
    end
    store(BASE + 32'd8, 32'h1);
    idle(6 * 41);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds to the ARM core's data-bus stores (MemWrite/DataAdr/WriteData) and serializes bytes onto a single tx line, 8N1, LSB first. It decodes a 3-word register window, buffers bytes in a small FIFO, and returns status on ReadData so firmware can poll before storing. It sits beside dmem in top_sim; the top muxes ReadData using hit.

Parameters:
BASE_ADDR, 32'h0000_0100, word-aligned base of register window
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
FIFO_DEPTH, 4, TX byte FIFO entries (power of two)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low
MemWrite  input  1  store strobe from core
DataAdr  input  32  byte address from core
WriteData  input  32  store data from core
ReadData  output  32  register read data, combinational
hit  output  1  DataAdr within window
tx  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset (reset==0 at rising edge): tx=1, busy=0, FIFO emptied, FSM=IDLE, enable=1, overflow=0. Reset mid-frame aborts the frame; tx is high after that edge.
- Decode: DataAdr[1:0] ignored. Offsets 0x0 TXDATA, 0x4 STATUS, 0x8 CTRL; hit=1 only for these three words.
- ReadData (combinational, independent of MemWrite): TXDATA->0; STATUS->{25'b0, overflow[6], count[5:3], busy[2], empty[1], full[0]}; CTRL->{31'b0, enable}; no hit->0.
- Push: MemWrite & TXDATA & !full writes WriteData[7:0] at the rising edge. Store while full is dropped and sets overflow. full is sampled before the edge, so a same-cycle pop does not rescue a store made while full.
- Overflow clear: store to STATUS with WriteData[6]=1. Other STATUS bits are read-only.
- CTRL store: enable<=WriteData[0]. Disabling mid-frame lets the current frame finish; no new pops while enable=0.
- FSM IDLE: if enable & !empty at an edge, pop the head into the shift register, reset bit counter and baud counter, go to START. Push and pop in the same cycle are both allowed; count is unchanged.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right, 8 bits LSB first, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- busy=1 in START/DATA/STOP.
- Latency: tx falls one cycle after the push edge when IDLE and non-empty. A frame is 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly one IDLE cycle (tx high) between STOP and the next START.
- Counters: baud counter width clog2(CLKS_PER_BIT); FIFO pointers wrap modulo FIFO_DEPTH; count has clog2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH.

Test Plan:
1. Reset held 3 cycles, release -> tx=1, busy=0; load from BASE+4 returns 0x00000002; load from BASE+8 returns 0x00000001.
2. CLKS_PER_BIT=4; store 0x41 to BASE -> tx low 1 cycle after the store edge for 4 cycles; data 1,0,0,0,0,0,1,0 at 4 cycles each; stop high 4 cycles; busy high for exactly 40 cycles.
3. Six consecutive-cycle stores 0x0D,0x31,0x33,0x37,0x33,0x30 -> first five transmitted in order with 1-cycle gaps; sixth dropped; STATUS bit6=1; store 0x40 to BASE+4 clears it.
4. Store 0 to CTRL, then push 0xAA and 0x55 -> tx stays high, STATUS=0x00000010; store 1 to CTRL -> frames for 0xAA then 0x55 follow.
5. Assert reset during the DATA bit 3 of 0x0F -> tx=1 and busy=0 after that edge; after release STATUS=0x2 and no frame appears.
6. Store to BASE+0xC and to dmem address 0x8 -> hit=0, ReadData=0, FIFO count unchanged, tx idle.
